// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state type and default timing constants for the alarm controller
package alarm_pkg;
  typedef enum logic [1:0] {OFF, ARMED, RING, SNOOZE} alarm_state_t;
  localparam int RING_SEC_DEF   = 300;
  localparam int SNOOZE_SEC_DEF = 540;
  localparam int MAX_SNOOZE_DEF = 3;
endpackage

// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: button/comparator inputs and buzzer outputs of the alarm controller
interface alarm_ctrl_if #(parameter int MAX_SNOOZE = alarm_pkg::MAX_SNOOZE_DEF);
  logic alarm_on;
  logic match;
  logic snooze;
  logic stop;
  logic buzz;
  logic snoozing;
  logic [$clog2(MAX_SNOOZE+1)-1:0] snz_used;
  modport master (output alarm_on, match, snooze, stop, input buzz, snoozing, snz_used);
  modport slave  (input alarm_on, match, snooze, stop, output buzz, snoozing, snz_used);
endinterface

// File: rtl/alarm_ctrl_ct_down.sv
// ct_down_N: loadable down-counter that loads N-1, counts to 0 and holds there
module ct_down_N #(parameter int N = 2) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam int W = $clog2(N);
  logic [W-1:0] q;
  // clear beats load beats decrement; never wraps below 0
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (load) q <= W'(N - 1);
    else if (en && q != '0) q <= q - 1'b1;
  assign zero = (q == '0);
endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm ring/snooze/dismiss sequencer; define ALARM_BEEP_EN for 0.5 Hz pulsed buzz
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input logic clk,
  input logic rst,
  alarm_ctrl_if.slave bus
);
  localparam int UW = $clog2(MAX_SNOOZE + 1);
  localparam logic [UW-1:0] MAX_U = UW'(MAX_SNOOZE);
  alarm_state_t state, nstate;
  logic match_d, ring_start;
  logic [UW-1:0] snz_used;
  logic clr, ring_load, ring_en, ring_zero, snz_load, snz_en, snz_zero, used_clr, used_inc;
  assign ring_start = bus.match & ~match_d;
  ct_down_N #(.N(RING_SEC)) ring_ct (
    .clk(clk), .rst(rst), .clr(clr), .load(ring_load), .en(ring_en), .zero(ring_zero)
  );
  ct_down_N #(.N(SNOOZE_SEC)) snz_ct (
    .clk(clk), .rst(rst), .clr(clr), .load(snz_load), .en(snz_en), .zero(snz_zero)
  );
  // state, match edge history and snooze tally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= OFF;
      match_d  <= 1'b0;
      snz_used <= '0;
    end else begin
      state    <= nstate;
      match_d  <= bus.match;
      snz_used <= used_clr ? '0 : used_inc ? snz_used + 1'b1 : snz_used;
    end
  // next state and counter controls; enable, then stop, then snooze, then expiry
  always_comb begin
    nstate    = state;
    clr       = 1'b0;
    ring_load = 1'b0;
    ring_en   = 1'b0;
    snz_load  = 1'b0;
    snz_en    = 1'b0;
    used_clr  = 1'b0;
    used_inc  = 1'b0;
    if (!bus.alarm_on) begin
      nstate   = OFF;
      clr      = 1'b1;
      used_clr = 1'b1;
    end else
      case (state)
        OFF: nstate = ARMED;
        ARMED:
          if (ring_start) begin
            nstate    = RING;
            ring_load = 1'b1;
          end
        RING:
          if (bus.stop) begin
            nstate   = ARMED;
            used_clr = 1'b1;
          end else if (bus.snooze && snz_used < MAX_U) begin
            nstate   = SNOOZE;
            snz_load = 1'b1;
            used_inc = 1'b1;
          end else if (ring_zero) begin
            nstate   = ARMED;
            used_clr = 1'b1;
          end else ring_en = 1'b1;
        default:
          if (bus.stop) begin
            nstate   = ARMED;
            used_clr = 1'b1;
          end else if (snz_zero) begin
            nstate    = RING;
            ring_load = 1'b1;
          end else snz_en = 1'b1;
      endcase
  end
`ifdef ALARM_BEEP_EN
  logic beep;
  // beep phase starts on at every RING entry and alternates while ringing
  always_ff @(posedge clk or posedge rst)
    if (rst) beep <= 1'b0;
    else if (nstate == RING && state != RING) beep <= 1'b1;
    else if (state == RING) beep <= ~beep;
  assign bus.buzz = (state == RING) & beep;
`else
  assign bus.buzz = (state == RING);
`endif
  assign bus.snoozing = (state == SNOOZE);
  assign bus.snz_used = snz_used;
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed scoreboard bench for alarm_ctrl (RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2)
module tb_alarm_ctrl;
  typedef struct {
    string tag;
    logic [3:0] v;
  } exp_t;
`ifdef ALARM_BEEP_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  alarm_ctrl_if #(.MAX_SNOOZE(2)) bus ();
  alarm_ctrl #(.RING_SEC(5), .SNOOZE_SEC(3), .MAX_SNOOZE(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic rb(input int k);
    return BEEP ? k[0] : 1'b1;
  endfunction
  task automatic compare();
    exp_t e;
    logic [3:0] got;
    e = sb.pop_front();
    got = {bus.buzz, bus.snoozing, bus.snz_used};
    checks++;
    assert (got === e.v) else begin
      errors++;
      $error("FAIL %s got buzz/snoozing/snz_used=%b expected %b", e.tag, got, e.v);
    end
  endtask
  task automatic cyc(input string tag, input logic on, m, sn, st, input logic [3:0] exp);
    bus.alarm_on = on;
    bus.match = m;
    bus.snooze = sn;
    bus.stop = st;
    sb.push_back('{tag, exp});
    @(posedge clk);
    #1;
    compare();
  endtask
  initial begin
    bus.alarm_on = 1'b0;
    bus.match = 1'b0;
    bus.snooze = 1'b0;
    bus.stop = 1'b0;
    #2;
    sb.push_back('{"reset", 4'b0000});
    compare();
    #1 rst = 1'b0;
    cyc("arm", 1, 0, 0, 0, 4'b0000);
    for (int k = 1; k <= 5; k++) cyc("ring_timeout", 1, 1, 0, 0, {rb(k), 3'b000});
    for (int k = 0; k < 15; k++) cyc("no_rering", 1, 1, 0, 0, 4'b0000);
    cyc("match_fall", 1, 0, 0, 0, 4'b0000);
    cyc("snz_ring1", 1, 1, 0, 0, {rb(1), 3'b000});
    cyc("snz_ring2", 1, 1, 0, 0, {rb(2), 3'b000});
    cyc("snooze1", 1, 1, 1, 0, 4'b0101);
    cyc("snooze1_held", 1, 1, 1, 0, 4'b0101);
    cyc("snooze1_last", 1, 1, 0, 0, 4'b0101);
    cyc("rering1", 1, 1, 0, 0, {rb(1), 3'b001});
    cyc("rering1_c2", 1, 1, 0, 0, {rb(2), 3'b001});
    cyc("snooze2", 1, 1, 1, 0, 4'b0110);
    cyc("snooze2_b", 1, 1, 0, 0, 4'b0110);
    cyc("snooze2_c", 1, 1, 0, 0, 4'b0110);
    cyc("rering2", 1, 1, 0, 0, {rb(1), 3'b010});
    cyc("snooze3_ignored", 1, 1, 1, 0, {rb(2), 3'b010});
    for (int k = 3; k <= 5; k++) cyc("exhausted_ring", 1, 1, 0, 0, {rb(k), 3'b010});
    cyc("exhausted_timeout", 1, 1, 0, 0, 4'b0000);
    cyc("stop_arm", 1, 0, 0, 0, 4'b0000);
    cyc("stop_ring", 1, 1, 0, 0, {rb(1), 3'b000});
    cyc("stop_snooze_in", 1, 1, 1, 0, 4'b0101);
    cyc("stop_in_snooze", 1, 1, 0, 1, 4'b0000);
    for (int k = 0; k < 3; k++) cyc("stop_no_ring", 1, 1, 0, 0, 4'b0000);
    cyc("dis_arm", 1, 0, 0, 0, 4'b0000);
    cyc("dis_ring", 1, 1, 0, 0, {rb(1), 3'b000});
    cyc("disable_ring", 0, 1, 0, 0, 4'b0000);
    cyc("reenable_mid", 1, 1, 0, 0, 4'b0000);
    cyc("reenable_hold1", 1, 1, 0, 0, 4'b0000);
    cyc("reenable_hold2", 1, 1, 0, 0, 4'b0000);
    cyc("reenable_fall", 1, 0, 0, 0, 4'b0000);
    cyc("reenable_rise", 1, 1, 0, 0, {rb(1), 3'b000});
    cyc("dis_snooze_in", 1, 1, 1, 0, 4'b0101);
    cyc("disable_snooze", 0, 1, 0, 0, 4'b0000);
    cyc("sim_arm", 1, 0, 0, 0, 4'b0000);
    cyc("sim_ring", 1, 1, 0, 0, {rb(1), 3'b000});
    cyc("stop_and_snooze", 1, 1, 1, 1, 4'b0000);
    cyc("rst_arm", 1, 0, 0, 0, 4'b0000);
    cyc("rst_ring", 1, 1, 0, 0, {rb(1), 3'b000});
    #2 rst = 1'b1;
    #1;
    sb.push_back('{"async_rst", 4'b0000});
    compare();
    #1 rst = 1'b0;
    cyc("post_rst_arm", 1, 1, 0, 0, 4'b0000);
    cyc("post_rst_no_ring", 1, 1, 0, 0, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm sequencing controller for the 1 Hz alarm-clock datapath. It receives the level-sensitive time==alarm match from the alarm comparator and the user's alarm-enable, snooze and stop buttons, and produces the buzzer drive. The FSM handles ring start on a match edge, ring timeout, a bounded snooze count and dismissal. It sits between the comparator and the Buzz output of the top-level clock.

## Interface
- `RING_SEC`, default 300: cycles (seconds) the buzzer rings before auto-timeout; ≥2.
- `SNOOZE_SEC`, default 540: cycles of silence per snooze; ≥2.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; ≥1.
- `clk`  in  1: one cycle per second (Pulse).
- `rst`  in  1: reset; asynchronous, active-high.
- `alarm_on`  in  1: user alarm enable, level.
- `match`  in  1: comparator output; high for the entire matching minute.
- `snooze`  in  1: snooze request, sampled each edge.
- `stop`  in  1: dismiss request, sampled each edge.
- `buzz`  out  1: buzzer drive.
- `snoozing`  out  1: high while in SNOOZE.
- `snz_used`  out  $clog2(MAX_SNOOZE+1): snoozes consumed in the current event.

## Operation
- States are OFF, ARMED, RING and SNOOZE. The reset state is OFF.
- `match_d` registers `match` every cycle in all states and resets to 0.
- `ring_start` = `match & ~match_d`.
- Priority at each edge is: `alarm_on`=0, then `stop`, then `snooze`, then timer expiry.
- **Any state, `alarm_on`=0:** go to OFF. `snz_used` and both timers are cleared.
- **OFF:** when `alarm_on`=1, go to ARMED. Enabling mid-minute while `match` is already high does not ring, because there is no rising edge.
- **ARMED:** `ring_start` moves to RING and loads `ring_ct`=RING_SEC-1.
- **RING:**
  - `stop` goes to ARMED and sets `snz_used`=0.
  - `snooze` with `snz_used`<MAX_SNOOZE goes to SNOOZE, loads `snz_ct`=SNOOZE_SEC-1 and increments `snz_used`.
  - `snooze` with `snz_used`==MAX_SNOOZE is ignored; the block stays in RING and `ring_ct` keeps counting.
  - `ring_ct`==0 goes to ARMED and sets `snz_used`=0.
  - Otherwise `ring_ct` decrements.
- **SNOOZE:**
  - `stop` goes to ARMED and sets `snz_used`=0.
  - `snz_ct`==0 goes to RING and reloads `ring_ct`=RING_SEC-1.
  - Otherwise `snz_ct` decrements.
  - `snooze` is ignored in this state.
- A new `ring_start` arriving while in RING or SNOOZE is ignored.
- `buzz` is decoded from the state register: `buzz`=(state==RING), subject to Configuration.
- `snoozing`=(state==SNOOZE).
- Counters never wrap. Each counter is loaded on state entry and holds at 0 only for its exit cycle.

## Timing
- Reset values: state=OFF, `buzz`=0, `snoozing`=0, `snz_used`=0, `match_d`=0, `ring_ct`=0, `snz_ct`=0.
- If `ring_start` is true at edge t, `buzz`=1 in the cycle after t.
- With no buttons pressed, RING lasts exactly RING_SEC cycles and SNOOZE lasts exactly SNOOZE_SEC cycles.
- Button effects take one edge. Buttons are level-sampled, so a multi-cycle `snooze` press consumes one snooze, because SNOOZE ignores `snooze`.
- Asserting `rst` mid-RING drops `buzz` immediately, without waiting for a clock edge.

## Configuration
- Macro `ALARM_BEEP_EN` defined:
  - A `beep` phase flop is set to 1 on every entry to RING and toggles each cycle while in RING.
  - `buzz`=(state==RING) & `beep`, giving on/off at 0.5 Hz starting with on.
  - The flop resets to 0.
- Macro undefined: `buzz` is steady high throughout RING and the phase flop is absent.

## Structure
- Package `alarm_pkg` holds:
  - the `typedef enum logic [1:0] {OFF, ARMED, RING, SNOOZE} alarm_state_t`;
  - default constants for RING_SEC, SNOOZE_SEC and MAX_SNOOZE.
- Sub-module `ct_down_N`: a loadable down-counter with `load`, `en` and `zero`, parameter N, width $clog2(N). It is instantiated twice, for `ring_ct` and `snz_ct`.

## Test plan
All scenarios use RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2, with the macro undefined unless stated.
- **Timeout and no re-ring:** `alarm_on`=1, `match` rises and holds for 20 cycles → `buzz` high for exactly 5 cycles, then ARMED, and no second ring while `match` stays high.
- **Snooze to exhaustion:**
  - `snooze` pulse on ring cycle 2 → `buzz`=0 and `snoozing`=1 for 3 cycles, `snz_used`=1, then `buzz` high again.
  - Repeat once → `snz_used`=2.
  - A third `snooze` is ignored, and the ring times out at 5 cycles → `snz_used`=0.
- **Stop during snooze:** `stop` pressed in SNOOZE → ARMED on the next edge, `snoozing`=0, `snz_used`=0, and no ring when `snz_ct` would have hit 0.
- **Disable mid-ring:** `alarm_on`=0 while ringing → OFF and `buzz`=0 next cycle. Re-enabling while `match`=1 → no ring until `match` falls and rises again.
- **Simultaneous inputs, then reset:**
  - `stop`=`snooze`=1 in RING → ARMED, with `snz_used` unchanged at 0.
  - Async `rst` pulse mid-RING → all outputs 0 immediately, state OFF.
- **`ALARM_BEEP_EN` defined:** ring of 5 cycles → `buzz` pattern 1,0,1,0,1, then 0.
